// File: rtl/aurora_tx_lane.sv
// -----------------------------------------------------------------------------
// aurora_tx_lane
//
// 64b66b Aurora transmit lane. User blocks (64-bit payload + 2-bit sync
// header) are scrambled with the self-synchronous x^58+x^39+1 scrambler in
// the accept cycle. A 66-to-32 gearbox then emits one 32-bit word per clock
// to the serializer. Whenever the gearbox has room for a block and none is
// offered, an idle control block is inserted so the serial stream never
// underruns.
//
// Ports:
//   clk_tx_i         in   1   lane word clock
//   rst_n_i          in   1   asynchronous active-low reset
//   tx_data_i        in  64   block payload
//   tx_header_i      in   2   sync header (01 data, 10 control)
//   tx_valid_i       in   1   block offered
//   tx_ready_o       out  1   block taken on an edge with tx_valid_i & tx_ready_o
//   tx_polarity_i    in   1   1 = invert every bit of tx_word_o
//   tx_word_o        out 32   gearbox output, bit 31 transmitted first
//   tx_word_valid_o  out  1   tx_word_o holds valid bits
//   tx_stat_o        out  8   [6:0] saturating idle-insert count,
//                             [7] sticky invalid-header (00/11) flag
// -----------------------------------------------------------------------------
module aurora_tx_lane #(
  parameter bit          SCRAMBLE_EN    = 1'b1,
  parameter logic [65:0] IDLE_BLOCK     = {2'b10, 8'h78, 56'h0},
  parameter logic [57:0] SCRAMBLER_INIT = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic        clk_tx_i,
  input  logic        rst_n_i,
  input  logic [63:0] tx_data_i,
  input  logic [1:0]  tx_header_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic        tx_polarity_i,
  output logic [31:0] tx_word_o,
  output logic        tx_word_valid_o,
  output logic [7:0]  tx_stat_o
);

  localparam int BUF_W = 98;

  // Gearbox state. The buffer is left-aligned: the oldest bit sits at
  // buf_reg[97], valid bits occupy buf_reg[97 -: fill_reg], and every bit
  // below the valid region is kept at zero so a new block can be OR-ed in.
  logic [6:0]       fill_reg;
  logic [6:0]       fill_next;
  logic [BUF_W-1:0] buf_reg;
  logic [BUF_W-1:0] buf_next;

  // Scrambler state
  logic [57:0]      scr_reg;
  logic [57:0]      scr_next;

  // Output and status registers
  logic [31:0]      word_reg;
  logic [31:0]      word_next;
  logic             word_valid_reg;
  logic [6:0]       idle_cnt_reg;
  logic [6:0]       idle_cnt_next;
  logic             hdr_err_reg;
  logic             hdr_err_next;

  // Cycle decode, from registers only
  logic             out_en;
  logic             accept;

  // Block selected for the current accept slot
  logic [1:0]       blk_hdr;
  logic [63:0]      blk_data;
  logic [63:0]      scr_data;
  logic [63:0]      tx_payload;
  logic [BUF_W-1:0] buf_shift;
  logic [BUF_W-1:0] blk_aligned;

  assign out_en = (fill_reg >= 7'd32);
  assign accept = (fill_reg < 7'd64);

  // ---------------------------------------------------------------------------
  // Block selection: user block when offered, otherwise the idle block.
  // ---------------------------------------------------------------------------
  always_comb begin
    blk_hdr  = IDLE_BLOCK[65:64];
    blk_data = IDLE_BLOCK[63:0];
    if (tx_valid_i) begin
      blk_hdr  = tx_header_i;
      blk_data = tx_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Scrambler, unrolled over the 64 payload bits in transmit order
  // (data[63] first). Stage gi holds the state before bit 63-gi is processed.
  // ---------------------------------------------------------------------------
  logic [64:0][57:0] scr_chain;

  assign scr_chain[0] = scr_reg;

  for (genvar gi = 0; gi < 64; gi++) begin : g_scr
    logic s_bit;
    assign s_bit             = blk_data[63-gi] ^ scr_chain[gi][38] ^ scr_chain[gi][57];
    assign scr_data[63-gi]   = s_bit;
    assign scr_chain[gi+1]   = {scr_chain[gi][56:0], s_bit};
  end

  always_comb begin
    tx_payload = blk_data;
    scr_next   = scr_reg;
    if (SCRAMBLE_EN) begin
      tx_payload = scr_data;
      if (accept) begin
        scr_next = scr_chain[64];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Gearbox
  // ---------------------------------------------------------------------------
  // Drop the 32 oldest bits when a word is emitted.
  assign buf_shift = out_en ? {buf_reg[BUF_W-33:0], 32'h0} : buf_reg;

  // The new block goes right behind the bits that remain after the shift.
  // An accept only happens with fill < 64, so the remaining count is
  // fill - 32 (fill in 32..63) or fill (fill in 0..31); in both cases that is
  // simply fill_reg[4:0], which keeps the alignment shifter to 5 bits.
  assign blk_aligned = {blk_hdr, tx_payload, 32'h0} >> fill_reg[4:0];

  always_comb begin
    buf_next  = buf_shift;
    fill_next = fill_reg;
    if (out_en) begin
      fill_next = fill_next - 7'd32;
    end
    if (accept) begin
      buf_next  = buf_shift | blk_aligned;
      fill_next = fill_next + 7'd66;
    end
  end

  // Output word: polarity applies only to the word being registered.
  always_comb begin
    word_next = word_reg;
    if (out_en) begin
      word_next = buf_reg[BUF_W-1 -: 32] ^ {32{tx_polarity_i}};
    end
  end

  // ---------------------------------------------------------------------------
  // Status: idle-insert counter (saturating) and sticky bad-header flag.
  // ---------------------------------------------------------------------------
  always_comb begin
    idle_cnt_next = idle_cnt_reg;
    hdr_err_next  = hdr_err_reg;
    if (accept) begin
      if (!tx_valid_i) begin
        if (idle_cnt_reg != 7'h7F) begin
          idle_cnt_next = idle_cnt_reg + 7'd1;
        end
      end else if (tx_header_i == 2'b00 || tx_header_i == 2'b11) begin
        hdr_err_next = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_tx_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fill_reg       <= 7'd0;
      buf_reg        <= '0;
      scr_reg        <= SCRAMBLER_INIT;
      word_reg       <= 32'h0;
      word_valid_reg <= 1'b0;
      idle_cnt_reg   <= 7'd0;
      hdr_err_reg    <= 1'b0;
    end else begin
      fill_reg       <= fill_next;
      buf_reg        <= buf_next;
      scr_reg        <= scr_next;
      word_reg       <= word_next;
      word_valid_reg <= out_en;
      idle_cnt_reg   <= idle_cnt_next;
      hdr_err_reg    <= hdr_err_next;
    end
  end

  assign tx_ready_o      = accept;
  assign tx_word_o       = word_reg;
  assign tx_word_valid_o = word_valid_reg;
  assign tx_stat_o       = {hdr_err_reg, idle_cnt_reg};

endmodule

// File: tb/tb_aurora_tx_lane.sv
// -----------------------------------------------------------------------------
// tb_aurora_tx_lane
//
// Directed bench for aurora_tx_lane. Two instances share all inputs: u0 with
// the scrambler bypassed, u1 with it enabled. A monitor collects the emitted
// bit streams (polarity removed) and the 66-bit blocks offered at each accept
// slot; each test task compares these against hand-computed values or a
// reference descrambler.
// -----------------------------------------------------------------------------
module tb_aurora_tx_lane;

  localparam logic [65:0] IDLE  = {2'b10, 8'h78, 56'h0};
  localparam logic [57:0] SINIT = 58'h3FF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] data;
  logic [1:0]  hdr;
  logic        valid;
  logic        pol;

  logic        ready0, ready1;
  logic [31:0] word0, word1;
  logic        wv0, wv1;
  logic [7:0]  stat0, stat1;

  int tests_run    = 0;
  int tests_failed = 0;

  // Monitor state
  bit rec_en     = 1'b0;
  bit seen_valid = 1'b0;
  bit out0_q[$];
  bit out1_q[$];
  bit exp_q[$];
  int idle_exp  = 0;
  int stall_cnt = 0;

  always #5 clk = ~clk;

  aurora_tx_lane #(.SCRAMBLE_EN(1'b0)) u0 (
    .clk_tx_i(clk), .rst_n_i(rst_n), .tx_data_i(data), .tx_header_i(hdr),
    .tx_valid_i(valid), .tx_ready_o(ready0), .tx_polarity_i(pol),
    .tx_word_o(word0), .tx_word_valid_o(wv0), .tx_stat_o(stat0)
  );

  aurora_tx_lane #(.SCRAMBLE_EN(1'b1)) u1 (
    .clk_tx_i(clk), .rst_n_i(rst_n), .tx_data_i(data), .tx_header_i(hdr),
    .tx_valid_i(valid), .tx_ready_o(ready1), .tx_polarity_i(pol),
    .tx_word_o(word1), .tx_word_valid_o(wv1), .tx_stat_o(stat1)
  );

  // Inputs change only at posedge+1, so at the negedge they show exactly what
  // the next edge will see.
  initial begin
    logic [65:0] blk;
    forever begin
      @(negedge clk);
      if (rec_en && rst_n) begin
        if (wv0) begin
          seen_valid = 1'b1;
          for (int i = 31; i >= 0; i--) out0_q.push_back(word0[i] ^ pol);
        end else if (seen_valid) begin
          stall_cnt++;
        end
        if (wv1) begin
          for (int i = 31; i >= 0; i--) out1_q.push_back(word1[i] ^ pol);
        end
        if (ready0) begin
          blk = valid ? {hdr, data} : IDLE;
          if (!valid) idle_exp++;
          for (int i = 65; i >= 0; i--) exp_q.push_back(blk[i]);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rec();
    out0_q.delete();
    out1_q.delete();
    exp_q.delete();
    idle_exp   = 0;
    stall_cnt  = 0;
    seen_valid = 1'b0;
  endtask

  // Reset for a few cycles, then release at posedge+1 with recording enabled.
  task automatic do_reset();
    rec_en = 1'b0;
    rst_n  = 1'b0;
    repeat (3) tick();
    clear_rec();
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    rec_en = 1'b1;
  endtask

  // Reference descrambler over u1's stream, block-aligned against exp_q.
  task automatic scan_dut1(output int blocks, output int data_errs, output int hdr_errs);
    logic [57:0] st;
    bit s, d;
    int n;
    st = SINIT;
    blocks = 0; data_errs = 0; hdr_errs = 0;
    n = (out1_q.size() < exp_q.size()) ? out1_q.size() : exp_q.size();
    for (int k = 0; 66*k + 65 < n; k++) begin
      for (int j = 0; j < 2; j++)
        if (out1_q[66*k+j] != exp_q[66*k+j]) hdr_errs++;
      for (int j = 2; j < 66; j++) begin
        s  = out1_q[66*k+j];
        d  = s ^ st[38] ^ st[57];
        st = {st[56:0], s};
        if (d != exp_q[66*k+j]) data_errs++;
      end
      blocks++;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    valid = 1'b0; hdr = 2'b01; data = 64'h0; pol = 1'b0;
    rec_en = 1'b0;
    rst_n  = 1'b0;
    repeat (3) tick();
    tests_run++;
    if (word0 !== 32'h0 || wv0 !== 1'b0 || stat0 !== 8'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got word=%h valid=%b stat=%h, expected 0/0/0", word0, wv0, stat0);
    end
    tests_run++;
    if (word1 !== 32'h0 || ready0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_u1_ready: got word1=%h ready=%b, expected 0/1", word1, ready0);
    end
    clear_rec();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();  // edge 1: fill 0 -> 66
    tests_run++;
    if (wv0 !== 1'b0 || stat0 !== 8'd1 || ready0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL edge1: got valid=%b stat=%h ready=%b, expected 0/01/0", wv0, stat0, ready0);
    end
    tick();  // edge 2: first word, fill 34
    tests_run++;
    if (wv0 !== 1'b1 || word0 !== 32'h9E00_0000) begin
      tests_failed++;
      $display("FAIL first_word: got valid=%b word=%h, expected 1/9e000000", wv0, word0);
    end
    tests_run++;
    if (stat0 !== 8'd1 || ready0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL edge2: got stat=%h ready=%b, expected 01/1", stat0, ready0);
    end
    tick();  // edge 3: fill 68
    tests_run++;
    if (word0 !== 32'h0 || stat0 !== 8'd2 || ready0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL edge3: got word=%h stat=%h ready=%b, expected 00000000/02/0", word0, stat0, ready0);
    end
    tick();  // edge 4: tail of idle 0 + head of idle 1, fill 36
    tests_run++;
    if (word0 !== 32'h2780_0000 || ready0 !== 1'b1 || wv0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL edge4: got word=%h ready=%b valid=%b, expected 27800000/1/1", word0, ready0, wv0);
    end
    $display("[TB] reset: startup words checked");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_stream();
    logic [31:0] cnt;
    bit took;
    int low0, low1, errs, n, blocks, derrs, herrs;
    cnt = 0; low0 = 0; low1 = 0;
    valid = 1'b1; hdr = 2'b01; data = {cnt, cnt}; pol = 1'b0;
    do_reset();
    for (int c = 0; c < 200; c++) begin
      took = ready0;
      if (c >= 100 && c < 133) begin
        if (!ready0) low0++;
        if (!ready1) low1++;
      end
      tick();
      if (took) begin
        cnt++;
        data = {cnt, cnt};
      end
    end
    tests_run++;
    if (stat0[6:0] !== 7'd0) begin
      tests_failed++;
      $display("FAIL stream_idle_cnt: got %0d, expected 0", stat0[6:0]);
    end
    valid = 1'b0;
    repeat (10) tick();
    rec_en = 1'b0;
    $display("[TB] stream: %0d user blocks accepted", cnt);
    tests_run++;
    if (low0 != 17 || low1 != 17) begin
      tests_failed++;
      $display("FAIL stream_ready_low: got %0d/%0d of 33, expected 17", low0, low1);
    end
    n = (out0_q.size() < exp_q.size()) ? out0_q.size() : exp_q.size();
    errs = 0;
    for (int i = 0; i < n; i++) if (out0_q[i] != exp_q[i]) errs++;
    tests_run++;
    if (n < 6000 || errs != 0) begin
      tests_failed++;
      $display("FAIL stream_plain_bits: got %0d errors over %0d bits, expected 0 over >=6000", errs, n);
    end
    scan_dut1(blocks, derrs, herrs);
    tests_run++;
    if (blocks < 90 || derrs != 0) begin
      tests_failed++;
      $display("FAIL stream_descramble: got %0d errors over %0d blocks, expected 0 over >=90", derrs, blocks);
    end
    tests_run++;
    if (herrs != 0) begin
      tests_failed++;
      $display("FAIL stream_headers: got %0d header bit errors, expected 0", herrs);
    end
    tests_run++;
    if (stat0[6:0] !== idle_exp[6:0] || stat1[6:0] !== idle_exp[6:0]) begin
      tests_failed++;
      $display("FAIL stream_tail_idles: got %0d/%0d, expected %0d", stat0[6:0], stat1[6:0], idle_exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_sparse();
    bit took;
    int user_idx, order_errs, idle_seen, blocks, derrs, herrs;
    logic [65:0] b;
    valid = 1'b0; hdr = 2'b01; pol = 1'b0;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      data  = {k[31:0], k[31:0]};
      valid = 1'b1;
      took  = 1'b0;
      for (int w = 0; w < 4 && !took; w++) begin
        took = ready0;
        tick();
      end
      tests_run++;
      if (!took) begin
        tests_failed++;
        $display("FAIL sparse_accept_timeout: block %0d not taken in 4 cycles", k);
      end
      $display("[TB] sparse: block %0d offered, taken=%0d", k, took);
      valid = 1'b0;
      repeat (4) tick();
    end
    repeat (6) tick();
    rec_en = 1'b0;
    user_idx = 0; order_errs = 0; idle_seen = 0;
    for (int k = 0; 66*k + 65 < out0_q.size(); k++) begin
      for (int j = 0; j < 66; j++) b[65-j] = out0_q[66*k+j];
      if (b == IDLE) idle_seen++;
      else begin
        if (b !== {2'b01, user_idx[31:0], user_idx[31:0]}) order_errs++;
        user_idx++;
      end
    end
    tests_run++;
    if (order_errs != 0 || user_idx != 20) begin
      tests_failed++;
      $display("FAIL sparse_order: got %0d blocks with %0d order errors, expected 20 with 0", user_idx, order_errs);
    end
    tests_run++;
    if (stall_cnt != 0 || idle_seen == 0) begin
      tests_failed++;
      $display("FAIL sparse_continuity: got %0d stalls, %0d idles, expected 0 stalls and idles > 0", stall_cnt, idle_seen);
    end
    tests_run++;
    if (stat0[6:0] !== idle_exp[6:0] || idle_exp > 127) begin
      tests_failed++;
      $display("FAIL sparse_idle_cnt: got %0d, expected %0d", stat0[6:0], idle_exp);
    end
    scan_dut1(blocks, derrs, herrs);
    tests_run++;
    if (blocks < 40 || derrs != 0 || herrs != 0) begin
      tests_failed++;
      $display("FAIL sparse_descramble: got %0d/%0d errors over %0d blocks, expected 0/0 over >=40", derrs, herrs, blocks);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_bad_header();
    logic [65:0] b;
    valid = 1'b1; hdr = 2'b11; data = 64'h0123_4567_89AB_CDEF; pol = 1'b0;
    do_reset();
    tests_run++;
    if (stat0[7] !== 1'b0) begin
      tests_failed++;
      $display("FAIL badhdr_pre: got flag %b, expected 0", stat0[7]);
    end
    tick();  // accepted at edge 1
    valid = 1'b0; hdr = 2'b01;
    tests_run++;
    if (stat0[7] !== 1'b1 || stat1[7] !== 1'b1) begin
      tests_failed++;
      $display("FAIL badhdr_set: got flags %b/%b, expected 1/1", stat0[7], stat1[7]);
    end
    repeat (30) tick();
    rec_en = 1'b0;
    tests_run++;
    if (stat0[7] !== 1'b1 || stat0[6:0] !== idle_exp[6:0]) begin
      tests_failed++;
      $display("FAIL badhdr_sticky: got flag %b idles %0d, expected 1 and %0d", stat0[7], stat0[6:0], idle_exp);
    end
    b = '0;
    for (int j = 0; j < 66 && j < out0_q.size(); j++) b[65-j] = out0_q[j];
    tests_run++;
    if (b !== {2'b11, 64'h0123_4567_89AB_CDEF}) begin
      tests_failed++;
      $display("FAIL badhdr_block: got %h, expected %h", b, {2'b11, 64'h0123_4567_89AB_CDEF});
    end
    $display("[TB] bad header: block with header 11 sent");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_polarity();
    int errs, n, blocks, derrs, herrs;
    valid = 1'b0; hdr = 2'b01; data = 64'h0; pol = 1'b0;
    do_reset();
    repeat (30) tick();  // fill 62 after edge 30
    tests_run++;
    if (ready0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_ready62: got %b, expected 1", ready0);
    end
    tick();              // fill 96 after edge 31
    tests_run++;
    if (ready0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_ready96: got %b, expected 0", ready0);
    end
    #2;
    rec_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    tests_run++;
    if (word0 !== 32'h0 || wv0 !== 1'b0 || stat0 !== 8'h0 || word1 !== 32'h0) begin
      tests_failed++;
      $display("FAIL mid_async_reset: got word=%h valid=%b stat=%h word1=%h, expected all 0",
               word0, wv0, stat0, word1);
    end
    clear_rec();
    pol = 1'b1;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    rec_en = 1'b1;
    tick();
    tests_run++;
    if (wv0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL pol_edge1: got valid %b, expected 0", wv0);
    end
    tick();
    tests_run++;
    if (word0 !== 32'h61FF_FFFF || wv0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL pol_word1: got %h valid %b, expected 61ffffff 1", word0, wv0);
    end
    tick();
    tests_run++;
    if (word0 !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL pol_word2: got %h, expected ffffffff", word0);
    end
    tick();
    tests_run++;
    if (word0 !== 32'hD87F_FFFF) begin
      tests_failed++;
      $display("FAIL pol_word3: got %h, expected d87fffff", word0);
    end
    repeat (60) tick();
    rec_en = 1'b0;
    n = (out0_q.size() < exp_q.size()) ? out0_q.size() : exp_q.size();
    errs = 0;
    for (int i = 0; i < n; i++) if (out0_q[i] != exp_q[i]) errs++;
    tests_run++;
    if (n < 1500 || errs != 0) begin
      tests_failed++;
      $display("FAIL pol_stream: got %0d errors over %0d bits, expected 0 over >=1500", errs, n);
    end
    scan_dut1(blocks, derrs, herrs);
    tests_run++;
    if (blocks < 25 || derrs != 0 || herrs != 0) begin
      tests_failed++;
      $display("FAIL mid_scrambler_restart: got %0d/%0d errors over %0d blocks, expected 0/0 over >=25",
               derrs, herrs, blocks);
    end
    pol = 1'b0;
    $display("[TB] mid-reset and polarity sequence done");
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0; valid = 1'b0; hdr = 2'b01; data = 64'h0; pol = 1'b0;
    test_reset();
    test_stream();
    test_sparse();
    test_bad_header();
    test_reset_mid_polarity();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
